// File: rtl/airi5c_regfile_param_if.sv
// Bundle of the register file's CPU read/write ports and debug req/gnt port.
//   ra_i/rd_o      : NRD packed read ports (address in, combinational data out)
//   wen_i/wa_i/... : CPU write port, with optional pair write (wd2_i to wa_i+1)
//   ready_o        : init engine finished
//   dm_*           : debug-module access, one-cycle grant pulse with registered read data
// slave  : the register file side
// master : the pipeline / debug-module side
interface airi5c_regfile_param_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned NRD   = 3
);
  localparam int unsigned AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   ra_i;
  logic [NRD*XLEN-1:0] rd_o;
  logic                wen_i;
  logic [AW-1:0]       wa_i;
  logic [XLEN-1:0]     wd_i;
  logic [XLEN-1:0]     wd2_i;
  logic                use_rd64_i;
  logic                ready_o;
  logic                dm_req_i;
  logic                dm_we_i;
  logic [AW-1:0]       dm_addr_i;
  logic [XLEN-1:0]     dm_wd_i;
  logic                dm_gnt_o;
  logic [XLEN-1:0]     dm_rd_o;

  modport slave (
    input  ra_i, wen_i, wa_i, wd_i, wd2_i, use_rd64_i,
    input  dm_req_i, dm_we_i, dm_addr_i, dm_wd_i,
    output rd_o, ready_o, dm_gnt_o, dm_rd_o
  );

  modport master (
    output ra_i, wen_i, wa_i, wd_i, wd2_i, use_rd64_i,
    output dm_req_i, dm_we_i, dm_addr_i, dm_wd_i,
    input  rd_o, ready_o, dm_gnt_o, dm_rd_o
  );
endinterface

// File: rtl/airi5c_regfile_param.sv
// Parametrised integer register file.
//   clk_i  : core clock
//   rst_ni : asynchronous active-low reset (control state only, array is not reset)
//   bus    : airi5c_regfile_param_if.slave carrying the read ports, CPU write port,
//            ready flag and the debug req/gnt access port
// After reset an init engine walks x1..x(NREGS-1) writing INIT_BASE+i, one per cycle.
// x0 is never written and always reads as zero.
module airi5c_regfile_param #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NREGS     = 32,
  parameter int unsigned NRD       = 3,
  parameter bit          BYPASS    = 1'b1,
  parameter logic [31:0] INIT_BASE = 32'hdeadbe00
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  airi5c_regfile_param_if.slave bus
);
  localparam int unsigned AW = $clog2(NREGS);
  localparam logic [AW-1:0] LastIdx = AW'(NREGS - 1);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            gnt_q, gnt_d;
  logic [XLEN-1:0] dm_rd_q, dm_rd_d;

  logic [XLEN-1:0] mem_q [NREGS];

  logic            ready;
  logic            cpu_we;
  logic            dm_accept;
  logic [AW-1:0]   wa_hi;
  logic [XLEN-1:0] init_val;
  logic [XLEN-1:0] dm_mem_rd;

  assign ready     = (state_q == StRun);
  assign cpu_we    = bus.wen_i & ready;
  assign wa_hi     = bus.wa_i + AW'(1);
  assign init_val  = XLEN'(INIT_BASE) + XLEN'(cnt_q);
  // CPU writes have priority; ~gnt_q keeps a held request from being granted twice in a row.
  assign dm_accept = bus.dm_req_i & ready & ~bus.wen_i & ~gnt_q;
  assign dm_mem_rd = (bus.dm_addr_i == '0) ? '0 : mem_q[bus.dm_addr_i];

  // Init sequencer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StInit: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == LastIdx) state_d = StRun;
      end
      StRun: begin
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StInit;
      cnt_q   <= AW'(1);
      gnt_q   <= 1'b0;
      dm_rd_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      dm_rd_q <= dm_rd_d;
    end
  end

  // Debug port: grant pulse follows the accept edge; read data held until the next read.
  always_comb begin
    gnt_d   = dm_accept;
    dm_rd_d = dm_rd_q;
    if (dm_accept && !bus.dm_we_i) dm_rd_d = dm_mem_rd;
  end

  // Two array write ports: port A serves init, CPU low word and debug writes (mutually
  // exclusive by construction); port B serves the upper word of a pair write.
  logic            we_a, we_b;
  logic [AW-1:0]   addr_a, addr_b;
  logic [XLEN-1:0] data_a, data_b;

  always_comb begin
    we_a   = 1'b0;
    addr_a = '0;
    data_a = '0;
    we_b   = 1'b0;
    addr_b = '0;
    data_b = '0;
    if (state_q == StInit) begin
      we_a   = 1'b1;
      addr_a = cnt_q;
      data_a = init_val;
    end else if (cpu_we) begin
      we_a   = 1'b1;
      addr_a = bus.wa_i;
      data_a = bus.wd_i;
      we_b   = bus.use_rd64_i;
      addr_b = wa_hi;
      data_b = bus.wd2_i;
    end else if (dm_accept && bus.dm_we_i) begin
      we_a   = 1'b1;
      addr_a = bus.dm_addr_i;
      data_a = bus.dm_wd_i;
    end
    if (addr_a == '0) we_a = 1'b0;
    if (addr_b == '0) we_b = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (we_a) mem_q[addr_a] <= data_a;
    if (we_b) mem_q[addr_b] <= data_b;
  end

  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] a);
    logic [XLEN-1:0] v;
    v = mem_q[a];
    if (BYPASS && cpu_we) begin
      if (a == bus.wa_i) v = bus.wd_i;
      else if (bus.use_rd64_i && a == wa_hi) v = bus.wd2_i;
    end
    if (!ready || a == '0) v = '0;
    return v;
  endfunction

  always_comb begin
    bus.rd_o = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      bus.rd_o[k*XLEN +: XLEN] = read_port(bus.ra_i[k*AW +: AW]);
    end
  end

  assign bus.ready_o  = ready;
  assign bus.dm_gnt_o = gnt_q;
  assign bus.dm_rd_o  = dm_rd_q;
endmodule

// File: tb/tb_airi5c_regfile_param.sv
module tb_airi5c_regfile_param;
  localparam int unsigned NA = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  airi5c_regfile_param_if #(.XLEN(32), .NREGS(32), .NRD(3)) bus_a ();
  airi5c_regfile_param_if #(.XLEN(32), .NREGS(16), .NRD(2)) bus_b ();

  airi5c_regfile_param #(
    .XLEN(32), .NREGS(32), .NRD(3), .BYPASS(1'b1), .INIT_BASE(32'hdeadbe00)
  ) dut_a (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus_a)
  );

  airi5c_regfile_param #(
    .XLEN(32), .NREGS(16), .NRD(2), .BYPASS(1'b0), .INIT_BASE(32'hdeadbe00)
  ) dut_b (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus_b)
  );

  int checks = 0;
  int errs   = 0;

  // Reference model for dut_a: architectural register contents and debug port expectations.
  logic [31:0] mem [NA];
  int          init_cnt;
  bit          m_ready;
  bit          exp_gnt;
  logic [31:0] exp_dmrd;
  logic [31:0] sb_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    logic [4:0] nxt;
    nxt = bus_a.wa_i + 5'd1;
    if (!m_ready || a == 5'd0) return 32'd0;
    if (bus_a.wen_i) begin
      if (a == bus_a.wa_i) return bus_a.wd_i;
      if (bus_a.use_rd64_i && a == nxt) return bus_a.wd2_i;
    end
    return mem[a];
  endfunction

  // One clock of dut_a: called just after a negedge with inputs already driven.
  task automatic tick_a();
    bit          cw, acc, p, dwe;
    logic [4:0]  wa, nxt, daddr;
    logic [31:0] wd, wd2, dwd, drd;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rd_port%0d", k), bus_a.rd_o[k*32 +: 32], exp_read(bus_a.ra_i[k*5 +: 5]));
    end
    cw    = bus_a.wen_i && m_ready;
    acc   = bus_a.dm_req_i && m_ready && !bus_a.wen_i && !exp_gnt;
    wa    = bus_a.wa_i;
    nxt   = wa + 5'd1;
    wd    = bus_a.wd_i;
    wd2   = bus_a.wd2_i;
    p     = bus_a.use_rd64_i;
    dwe   = bus_a.dm_we_i;
    daddr = bus_a.dm_addr_i;
    dwd   = bus_a.dm_wd_i;
    drd   = (daddr == 5'd0) ? 32'd0 : mem[daddr];
    @(posedge clk);
    if (!m_ready) begin
      init_cnt++;
      if (init_cnt == NA - 1) m_ready = 1'b1;
    end
    if (cw) begin
      if (wa != 5'd0) mem[wa] = wd;
      if (p && nxt != 5'd0) mem[nxt] = wd2;
    end
    if (acc) begin
      if (dwe) begin
        if (daddr != 5'd0) mem[daddr] = dwd;
      end else begin
        exp_dmrd = drd;
      end
      sb_q.push_back(exp_dmrd);
    end
    exp_gnt = acc;
    @(negedge clk);
    chk("ready", {31'd0, bus_a.ready_o}, {31'd0, m_ready});
    chk("dm_gnt", {31'd0, bus_a.dm_gnt_o}, {31'd0, exp_gnt});
  endtask

  task automatic reset_all(input int hold);
    @(negedge clk);
    rst_n = 1'b0;
    bus_a.dm_req_i = 1'b0;
    bus_a.wen_i    = 1'b0;
    #1;
    chk("rst_ready", {31'd0, bus_a.ready_o}, 32'd0);
    chk("rst_gnt", {31'd0, bus_a.dm_gnt_o}, 32'd0);
    chk("rst_dm_rd", bus_a.dm_rd_o, 32'd0);
    m_ready  = 1'b0;
    init_cnt = 0;
    exp_gnt  = 1'b0;
    exp_dmrd = 32'd0;
    sb_q.delete();
    for (int i = 0; i < NA; i++) mem[i] = 32'hdeadbe00 + i;
    mem[0] = 32'd0;
    repeat (hold) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_ra(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
    bus_a.ra_i = {a2, a1, a0};
  endtask

  // Scoreboard monitor: every grant pulse must match the next queued debug read value.
  always @(negedge clk) begin
    if (rst_n && bus_a.dm_gnt_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL dm_unexpected_gnt: got grant, expected none at %0t", $time);
      end else begin
        chk("dm_rd", bus_a.dm_rd_o, sb_q.pop_front());
      end
    end
  end

  task automatic dm_b(input bit we, input logic [3:0] addr, input logic [31:0] wd);
    bus_b.dm_req_i  = 1'b1;
    bus_b.dm_we_i   = we;
    bus_b.dm_addr_i = addr;
    bus_b.dm_wd_i   = wd;
    @(negedge clk);
    chk("b_gnt", {31'd0, bus_b.dm_gnt_o}, 32'd1);
    bus_b.dm_req_i = 1'b0;
  endtask

  initial begin
    bus_a.ra_i = '0; bus_a.wen_i = 0; bus_a.wa_i = '0; bus_a.wd_i = '0; bus_a.wd2_i = '0;
    bus_a.use_rd64_i = 0; bus_a.dm_req_i = 0; bus_a.dm_we_i = 0; bus_a.dm_addr_i = '0;
    bus_a.dm_wd_i = '0;
    bus_b.ra_i = '0; bus_b.wen_i = 0; bus_b.wa_i = '0; bus_b.wd_i = '0; bus_b.wd2_i = '0;
    bus_b.use_rd64_i = 0; bus_b.dm_req_i = 0; bus_b.dm_we_i = 0; bus_b.dm_addr_i = '0;
    bus_b.dm_wd_i = '0;

    // Reset and full init sequence
    reset_all(2);
    set_ra(5'd5, 5'd0, 5'd31);
    repeat (NA - 1) tick_a();
    #1;
    chk("x5_init", bus_a.rd_o[31:0], 32'hdeadbe05);
    chk("x0_init", bus_a.rd_o[63:32], 32'd0);
    chk("x31_init", bus_a.rd_o[95:64], 32'hdeadbe1f);
    @(negedge clk);

    // Reset pulse partway through init restarts the walk
    reset_all(1);
    repeat (10) tick_a();
    reset_all(2);
    repeat (NA - 1) tick_a();
    chk("ready_after_restart", {31'd0, bus_a.ready_o}, 32'd1);

    // Same-cycle bypass of a single write
    bus_a.wen_i = 1; bus_a.wa_i = 5'd7; bus_a.wd_i = 32'h1234;
    set_ra(5'd7, 5'd8, 5'd0);
    #1 chk("bypass_x7", bus_a.rd_o[31:0], 32'h1234);
    tick_a();
    bus_a.wen_i = 0;
    tick_a();

    // Pair write at the top wraps onto x0 and is dropped there
    bus_a.wen_i = 1; bus_a.use_rd64_i = 1; bus_a.wa_i = 5'd31;
    bus_a.wd_i = 32'haaaa_0001; bus_a.wd2_i = 32'hbbbb_0002;
    set_ra(5'd31, 5'd0, 5'd1);
    tick_a();
    bus_a.wen_i = 0;
    tick_a();
    #1 chk("pair_x31", bus_a.rd_o[31:0], 32'haaaa_0001);
    chk("pair_x0", bus_a.rd_o[63:32], 32'd0);
    @(negedge clk);

    // Pair write at x4/x5 with both halves bypassed
    bus_a.wen_i = 1; bus_a.wa_i = 5'd4; bus_a.wd_i = 32'h4444_aaaa; bus_a.wd2_i = 32'h5555_bbbb;
    set_ra(5'd4, 5'd5, 5'd6);
    #1 chk("pair_byp_x5", bus_a.rd_o[63:32], 32'h5555_bbbb);
    tick_a();
    bus_a.wen_i = 0; bus_a.use_rd64_i = 0;
    tick_a();

    // Debug read waits behind three CPU writes
    bus_a.dm_req_i = 1; bus_a.dm_we_i = 0; bus_a.dm_addr_i = 5'd9;
    bus_a.wen_i = 1; bus_a.wa_i = 5'd3; bus_a.wd_i = 32'h3333;
    repeat (3) tick_a();
    bus_a.wen_i = 0;
    tick_a();
    chk("t5_gnt", {31'd0, bus_a.dm_gnt_o}, 32'd1);
    // Held request: grant every other cycle
    repeat (6) tick_a();
    bus_a.dm_req_i = 0;
    tick_a();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      set_ra(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      bus_a.wen_i      = ($urandom_range(0, 2) == 0);
      bus_a.wa_i       = 5'($urandom_range(0, 31));
      bus_a.wd_i       = $urandom;
      bus_a.wd2_i      = $urandom;
      bus_a.use_rd64_i = $urandom_range(0, 1);
      if (!bus_a.dm_req_i || exp_gnt) begin
        bus_a.dm_req_i  = ($urandom_range(0, 2) == 0);
        bus_a.dm_we_i   = $urandom_range(0, 1);
        bus_a.dm_addr_i = 5'($urandom_range(0, 31));
        bus_a.dm_wd_i   = $urandom;
      end
      tick_a();
    end
    bus_a.dm_req_i = 0;
    bus_a.wen_i    = 0;
    tick_a();
    tick_a();
    chk("sb_empty", sb_q.size(), 32'd0);

    // Second instance: 16 entries, 2 ports, no bypass
    chk("b_ready", {31'd0, bus_b.ready_o}, 32'd1);
    bus_b.wen_i = 1; bus_b.wa_i = 4'd7; bus_b.wd_i = 32'h1234;
    bus_b.ra_i = {4'd15, 4'd7};
    #1 chk("b_nobypass_old", bus_b.rd_o[31:0], 32'hdeadbe07);
    @(negedge clk);
    bus_b.wen_i = 0;
    #1 chk("b_nobypass_new", bus_b.rd_o[31:0], 32'h1234);
    chk("b_x15_init", bus_b.rd_o[63:32], 32'hdeadbe0f);
    @(negedge clk);
    dm_b(1'b1, 4'd15, 32'h0000cafe);
    #1 chk("b_x15_dmwr", bus_b.rd_o[63:32], 32'h0000cafe);
    @(negedge clk);
    chk("b_gnt_pulse", {31'd0, bus_b.dm_gnt_o}, 32'd0);
    dm_b(1'b1, 4'd0, 32'hffffffff);
    bus_b.ra_i = {4'd0, 4'd0};
    #1 chk("b_x0_dmwr", bus_b.rd_o[31:0], 32'd0);
    @(negedge clk);
    dm_b(1'b0, 4'd15, 32'd0);
    chk("b_dmrd_x15", bus_b.dm_rd_o, 32'h0000cafe);
    @(negedge clk);
    dm_b(1'b0, 4'd0, 32'd0);
    chk("b_dmrd_x0", bus_b.dm_rd_o, 32'd0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
